modrm_fetch_decoder: RTL and testbench
======================================

Name: modrm_fetch_decoder

Overview:
- Consumes the ModRM byte and any displacement bytes from the instruction prefetch queue.
- Produces mod, rm, reg and a 16-bit displacement for the physical address calculation stage.
- Sits between the prefetch queue and the EA/physical-address logic; the sequencer starts it once per ModRM-bearing opcode.
- Handles every 8086/V30 addressing form, including direct addressing (mod=00, rm=110) and register mode (mod=11).

Parameters:
- DISP8_SIGN_EXTEND, 1, 1: disp8 is sign-extended to 16 bits; 0: zero-extended (debug only).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse from sequencer: begin fetching ModRM
- flush  in  1  abort current fetch (branch/queue flush)
- queue_data  in  8  head byte of prefetch queue
- queue_valid  in  1  queue_data is valid
- queue_ready  out  1  byte is consumed at this rising edge when queue_valid=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; mod/rm/reg/displacement are valid
- mod  out  2  ModRM[7:6]
- reg_field  out  3  ModRM[5:3]
- rm  out  3  ModRM[2:0]
- displacement  out  16  extended displacement, 0 if none
- is_register  out  1  mod==2'b11
- bytes_used  out  2  bytes consumed: 1..3

Behaviour:
- Reset: state IDLE; all outputs 0, including queue_ready.
- States: IDLE, MODRM, DISP_LO, DISP_HI, DONE.
- IDLE: start=1 moves to MODRM next cycle. start is ignored in all other states.
- MODRM: queue_ready=1. When queue_valid=1, the edge latches mod/reg/rm, clears displacement and sets bytes_used=1. Next state:
  - DISP_LO if mod==01, mod==10, or (mod==00 and rm==110)
  - DONE otherwise
- DISP_LO: queue_ready=1. On a valid byte, displacement[7:0] is loaded and bytes_used increments.
  - If a disp8 form: displacement[15:8] = {8{byte[7]}} (or 0 when DISP8_SIGN_EXTEND=0), then DONE.
  - Else: go to DISP_HI.
- DISP_HI: queue_ready=1. On a valid byte, displacement[15:8] is loaded, bytes_used=3, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Wait states: queue_valid=0 in any fetch state holds the state; no byte is consumed.
- queue_ready depends only on state (plus start under the optional feature). It never depends combinationally on queue_valid.
- Outputs hold their values from DONE until the next ModRM byte is latched.
- busy=1 in MODRM, DISP_LO, DISP_HI and DONE.
- flush=1 in any state: queue_ready forced 0 that cycle, next state IDLE, done suppressed. flush has priority over start and over byte acceptance. Latched fields keep their values.
- Latency with the queue always valid (start at cycle 0): done at cycle 2 / 3 / 4 for 0 / 1 / 2 displacement bytes.
- Async reset mid-fetch: immediate return to IDLE with all outputs 0. Bytes already consumed are not restored; the sequencer must flush the queue.

Optional Feature:
- Macro: MODRM_FAST_START_EN.
- Defined:
  - In IDLE with start=1, queue_ready=1 and a valid byte is taken as the ModRM at that edge, skipping MODRM. Latency drops by one cycle: 1/2/3.
  - If queue_valid=0, the block goes to MODRM as normal.
  - flush still wins.
- Undefined: queue_ready is 0 in IDLE, giving the baseline timing above.

Decomposition:
- Shared package (cpu_pkg) holds:
  - modrm_state_t enum
  - MOD_MEM_NODISP=2'b00, MOD_MEM_DISP8=2'b01, MOD_MEM_DISP16=2'b10, MOD_REG=2'b11
  - RM_DIRECT=3'b110
- No sub-module. Displacement-length decode is a function in the package, shared with the instruction length pre-decoder.

Test Plan:
- Register mode: start, queue byte 0xC3 → done at cycle 2; mod=11, reg=000, rm=011, is_register=1, displacement=0x0000, bytes_used=1.
- disp8 negative: bytes 0x46,0xFE → mod=01, rm=110, displacement=0xFFFE, bytes_used=2, done at cycle 3. Repeat with 0x46,0x7F → 0x007F.
- Direct address: bytes 0x06,0x34,0x12 → mod=00, rm=110, displacement=0x1234, bytes_used=3, done at cycle 4.
- Stalls: bytes 0x87,0x78,0x56 with queue_valid low for 2 cycles before each byte → displacement=0x5678, done at cycle 10. queue_ready stays high while stalled and no byte is double-consumed.
- Flush in DISP_HI after 0x86,0xAA → no done, IDLE next cycle, queue_ready=0 in the flush cycle. A new start with 0xC0 then completes normally.
- MODRM_FAST_START_EN defined: start with 0x40,0x10 valid from cycle 0 → done at cycle 2, displacement=0x0010. Undefined: done at cycle 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for ModRM handling: the fetch FSM state type,
// the mod/rm field encodings, and the displacement-length decode that the
// instruction length pre-decoder also uses.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MODRM   = 3'd1,
    DISP_LO = 3'd2,
    DISP_HI = 3'd3,
    DONE    = 3'd4
  } modrm_state_t;

  localparam logic [1:0] MOD_MEM_NODISP = 2'b00;
  localparam logic [1:0] MOD_MEM_DISP8  = 2'b01;
  localparam logic [1:0] MOD_MEM_DISP16 = 2'b10;
  localparam logic [1:0] MOD_REG        = 2'b11;
  localparam logic [2:0] RM_DIRECT      = 3'b110;

  // Number of displacement bytes following a ModRM byte (0, 1 or 2).
  // mod=00 with rm=110 is direct addressing and carries a 16-bit address.
  function automatic logic [1:0] modrm_disp_len(input logic [1:0] mod,
                                                input logic [2:0] rm);
    logic [1:0] len;
    len = 2'd0;
    unique case (mod)
      MOD_MEM_NODISP: len = (rm == RM_DIRECT) ? 2'd2 : 2'd0;
      MOD_MEM_DISP8:  len = 2'd1;
      MOD_MEM_DISP16: len = 2'd2;
      default:        len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/modrm_fetch_decoder_if.sv
// Bundle between the sequencer/prefetch queue and the ModRM fetch decoder.
// master: sequencer + queue side; slave: the decoder.
interface modrm_fetch_decoder_if;
  import cpu_pkg::*;

  logic        start;
  logic        flush;
  logic [7:0]  queue_data;
  logic        queue_valid;
  logic        queue_ready;
  logic        busy;
  logic        done;
  logic [1:0]  mod;
  logic [2:0]  reg_field;
  logic [2:0]  rm;
  logic [15:0] displacement;
  logic        is_register;
  logic [1:0]  bytes_used;

  modport master (
    output start, flush, queue_data, queue_valid,
    input  queue_ready, busy, done, mod, reg_field, rm, displacement,
           is_register, bytes_used
  );

  modport slave (
    input  start, flush, queue_data, queue_valid,
    output queue_ready, busy, done, mod, reg_field, rm, displacement,
           is_register, bytes_used
  );

endinterface

// File: rtl/modrm_fetch_decoder.sv
// ModRM fetch decoder: pulls the ModRM byte and up to two displacement bytes
// from the prefetch queue and presents mod/reg/rm plus a 16-bit displacement
// to the effective-address stage.
// Optional build macro MODRM_FAST_START_EN: accept the ModRM byte in the same
// cycle as start, saving one cycle of latency.
module modrm_fetch_decoder
  import cpu_pkg::*;
#(
  parameter bit DISP8_SIGN_EXTEND = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  modrm_fetch_decoder_if.slave bus
);

  modrm_state_t state;
  logic [1:0]   mod_q;
  logic [2:0]   reg_q;
  logic [2:0]   rm_q;
  logic [15:0]  disp_q;
  logic         is_reg_q;
  logic [1:0]   used_q;
  logic         busy_q;
  logic         done_q;

  logic         take_ready;
  logic         accept;
  modrm_state_t after_modrm;
  logic         after_modrm_done;

  // Queue handshake: ready is a function of state (and start when fast start
  // is built in); flush always blocks consumption.
  always_comb begin
    take_ready = 1'b0;
    unique case (state)
      MODRM, DISP_LO, DISP_HI: take_ready = 1'b1;
`ifdef MODRM_FAST_START_EN
      IDLE:                    take_ready = bus.start;
`else
      IDLE:                    take_ready = 1'b0;
`endif
      default:                 take_ready = 1'b0;
    endcase
    if (bus.flush) take_ready = 1'b0;
  end

  assign accept           = take_ready & bus.queue_valid;
  assign after_modrm_done = (modrm_disp_len(bus.queue_data[7:6], bus.queue_data[2:0]) == 2'd0);
  assign after_modrm      = after_modrm_done ? DONE : DISP_LO;

  // Fetch FSM with registered result fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mod_q    <= 2'b00;
      reg_q    <= 3'b000;
      rm_q     <= 3'b000;
      disp_q   <= 16'h0000;
      is_reg_q <= 1'b0;
      used_q   <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              busy_q <= 1'b1;
              state  <= MODRM;
              // Only reachable with fast start: ModRM taken on the start edge.
              if (accept) begin
                mod_q    <= bus.queue_data[7:6];
                reg_q    <= bus.queue_data[5:3];
                rm_q     <= bus.queue_data[2:0];
                is_reg_q <= (bus.queue_data[7:6] == MOD_REG);
                disp_q   <= 16'h0000;
                used_q   <= 2'd1;
                state    <= after_modrm;
                done_q   <= after_modrm_done;
              end
            end
          end
          MODRM: begin
            if (accept) begin
              mod_q    <= bus.queue_data[7:6];
              reg_q    <= bus.queue_data[5:3];
              rm_q     <= bus.queue_data[2:0];
              is_reg_q <= (bus.queue_data[7:6] == MOD_REG);
              disp_q   <= 16'h0000;
              used_q   <= 2'd1;
              state    <= after_modrm;
              done_q   <= after_modrm_done;
            end
          end
          DISP_LO: begin
            if (accept) begin
              disp_q[7:0] <= bus.queue_data;
              used_q      <= used_q + 2'd1;
              if (modrm_disp_len(mod_q, rm_q) == 2'd1) begin
                disp_q[15:8] <= {8{DISP8_SIGN_EXTEND & bus.queue_data[7]}};
                state        <= DONE;
                done_q       <= 1'b1;
              end else begin
                state <= DISP_HI;
              end
            end
          end
          DISP_HI: begin
            if (accept) begin
              disp_q[15:8] <= bus.queue_data;
              used_q       <= 2'd3;
              state        <= DONE;
              done_q       <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.queue_ready  = take_ready;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q & ~bus.flush;
  assign bus.mod          = mod_q;
  assign bus.reg_field    = reg_q;
  assign bus.rm           = rm_q;
  assign bus.displacement = disp_q;
  assign bus.is_register  = is_reg_q;
  assign bus.bytes_used   = used_q;

endmodule

// File: tb/tb_modrm_fetch_decoder.sv
// Directed bench for modrm_fetch_decoder with a scoreboard of expected
// decode results, popped when done is seen.
module tb_modrm_fetch_decoder;

`ifdef MODRM_FAST_START_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  modrm_fetch_decoder_if bus ();

  modrm_fetch_decoder #(.DISP8_SIGN_EXTEND(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0]  mod;
    logic [2:0]  reg_f;
    logic [2:0]  rm;
    logic [15:0] disp;
    logic        is_reg;
    logic [1:0]  used;
    logic [7:0]  cyc;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete fetch: start at cycle 0, bytes offered from cycle 0 with
  // `stall` idle cycles (counted while the decoder is ready) before each byte.
  task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int nb, input int stall,
                         input logic [1:0] e_mod, input logic [2:0] e_reg, input logic [2:0] e_rm,
                         input logic [15:0] e_disp, input logic e_isreg);
    logic [7:0] bytes [3];
    exp_t e, got;
    int idx, st_left;
    bit seen;
    bytes   = '{b0, b1, b2};
    idx     = 0;
    st_left = stall;
    seen    = 1'b0;
    e.mod    = e_mod;
    e.reg_f  = e_reg;
    e.rm     = e_rm;
    e.disp   = e_disp;
    e.is_reg = e_isreg;
    e.used   = nb[1:0];
    e.cyc    = 8'(1 + nb + stall * nb - FAST);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      if (cyc > 0) begin
        bus.start = 1'b0;
        if (bus.done) begin
          seen = 1'b1;
          got  = sb.pop_front();
          check("done_cycle",   cyc,                  {24'h0, got.cyc});
          check("mod",          bus.mod,              got.mod);
          check("reg_field",    bus.reg_field,        got.reg_f);
          check("rm",           bus.rm,               got.rm);
          check("displacement", bus.displacement,     got.disp);
          check("is_register",  bus.is_register,      got.is_reg);
          check("bytes_used",   bus.bytes_used,       got.used);
          check("bytes_taken",  idx,                  nb);
        end
      end
      if (!seen) begin
        bus.queue_valid = (st_left == 0) && (idx < nb);
        bus.queue_data  = (idx < nb) ? bytes[idx] : 8'h00;
        #1;
        if (cyc > 0 && bus.busy && !bus.done)
          check("ready_in_fetch", bus.queue_ready, 1'b1);
        if (bus.queue_ready && bus.queue_valid) begin
          idx++;
          st_left = stall;
        end else if (bus.queue_ready && st_left > 0) begin
          st_left--;
        end
        @(negedge clk);
      end
    end
    bus.queue_valid = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);
    check("idle_after_done", bus.busy, 1'b0);
  endtask

  initial begin
    int idx;
    bus.start       = 1'b0;
    bus.flush       = 1'b0;
    bus.queue_data  = 8'h00;
    bus.queue_valid = 1'b0;

    // Reset state
    #12;
    check("rst_queue_ready", bus.queue_ready, 1'b0);
    check("rst_busy",        bus.busy,        1'b0);
    check("rst_done",        bus.done,        1'b0);
    check("rst_disp",        bus.displacement, 16'h0000);
    check("rst_bytes_used",  bus.bytes_used,  2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Register mode, disp8 negative/positive, direct address, stalled disp16
    run_txn(8'hC3, 8'h00, 8'h00, 1, 0, 2'b11, 3'b000, 3'b011, 16'h0000, 1'b1);
    run_txn(8'h46, 8'hFE, 8'h00, 2, 0, 2'b01, 3'b000, 3'b110, 16'hFFFE, 1'b0);
    run_txn(8'h46, 8'h7F, 8'h00, 2, 0, 2'b01, 3'b000, 3'b110, 16'h007F, 1'b0);
    run_txn(8'h06, 8'h34, 8'h12, 3, 0, 2'b00, 3'b000, 3'b110, 16'h1234, 1'b0);
    run_txn(8'h87, 8'h78, 8'h56, 3, 2, 2'b10, 3'b000, 3'b111, 16'h5678, 1'b0);

    // Flush in DISP_HI after 0x86, 0xAA
    idx = 0;
    bus.start = 1'b1;
    for (int k = 0; k < 10 && idx < 2; k++) begin
      bus.queue_valid = 1'b1;
      bus.queue_data  = (idx == 0) ? 8'h86 : 8'hAA;
      #1;
      if (bus.queue_ready) idx++;
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("flush_prefix_taken", idx, 2);
    bus.queue_valid = 1'b1;
    bus.queue_data  = 8'h12;
    bus.flush       = 1'b1;
    #1;
    check("flush_ready_low", bus.queue_ready, 1'b0);
    check("flush_no_done",   bus.done,        1'b0);
    @(negedge clk);
    bus.flush       = 1'b0;
    bus.queue_valid = 1'b0;
    #1;
    check("flush_idle_busy",  bus.busy,         1'b0);
    check("flush_idle_done",  bus.done,         1'b0);
    check("flush_idle_ready", bus.queue_ready,  1'b0);
    check("flush_keep_mod",   bus.mod,          2'b10);
    check("flush_keep_disp",  bus.displacement, 16'h00AA);
    check("flush_keep_used",  bus.bytes_used,   2'd2);
    @(negedge clk);
    check("flush_later_done", bus.done, 1'b0);
    run_txn(8'hC0, 8'h00, 8'h00, 1, 0, 2'b11, 3'b000, 3'b000, 16'h0000, 1'b1);

    // Fast-start sensitive latency case
    run_txn(8'h40, 8'h10, 8'h00, 2, 0, 2'b01, 3'b000, 3'b000, 16'h0010, 1'b0);

    // Asynchronous reset in the middle of a fetch
    idx = 0;
    bus.start = 1'b1;
    for (int k = 0; k < 10 && idx < 1; k++) begin
      bus.queue_valid = 1'b1;
      bus.queue_data  = 8'h46;
      #1;
      if (bus.queue_ready) idx++;
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.queue_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy",  bus.busy,         1'b0);
    check("arst_mod",   bus.mod,          2'b00);
    check("arst_rm",    bus.rm,           3'b000);
    check("arst_ready", bus.queue_ready,  1'b0);
    check("arst_used",  bus.bytes_used,   2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_txn(8'hD8, 8'h00, 8'h00, 1, 0, 2'b11, 3'b011, 3'b000, 16'h0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
